// File: rtl/button_arbiter.sv
// Round-robin arbiter that lends a shared one-hot button bus to one of three
// requesters for a fixed hold time, followed by a forced all-zero gap.
module button_arbiter #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:1] req,
    output logic [3:1] b,
    output logic [1:0] gnt_id,
    output logic [3:1] ack,
    output logic       busy
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned ID_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic [ID_W-1:0]   last_id;
    logic [ID_W-1:0]   last_nx;
    logic [3:1]        b_nx;
    logic [ID_W-1:0]   gnt_nx;
    logic [3:1]        ack_nx;
    logic              busy_nx;

    logic [ID_W-1:0]   p0_c;
    logic [ID_W-1:0]   p1_c;
    logic [ID_W-1:0]   p2_c;
    logic [ID_W-1:0]   sel_c;
    logic              found_c;

    // Requester id to its bus line
    function automatic logic [3:1] onehot(input logic [ID_W-1:0] id);
        logic [3:1] v;
        v = 3'b000;
        case (id)
            2'd1:    v = 3'b001;
            2'd2:    v = 3'b010;
            2'd3:    v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

    // Round-robin pick: search starts just after the previous grantee
    always_comb begin
        p0_c    = 2'd1;
        p1_c    = 2'd2;
        p2_c    = 2'd3;
        sel_c   = 2'd0;
        found_c = 1'b0;
        case (last_id)
            2'd1: begin
                p0_c = 2'd2;
                p1_c = 2'd3;
                p2_c = 2'd1;
            end
            2'd2: begin
                p0_c = 2'd3;
                p1_c = 2'd1;
                p2_c = 2'd2;
            end
            default: begin
                p0_c = 2'd1;
                p1_c = 2'd2;
                p2_c = 2'd3;
            end
        endcase
        if ((req & onehot(p0_c)) != 3'b000) begin
            sel_c   = p0_c;
            found_c = 1'b1;
        end else if ((req & onehot(p1_c)) != 3'b000) begin
            sel_c   = p1_c;
            found_c = 1'b1;
        end else if ((req & onehot(p2_c)) != 3'b000) begin
            sel_c   = p2_c;
            found_c = 1'b1;
        end
    end

    // Next-state and next-output logic; outputs are registered from these
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        last_nx  = last_id;
        b_nx     = 3'b000;
        gnt_nx   = 2'd0;
        ack_nx   = 3'b000;
        busy_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (found_c) begin
                    state_nx = GRANT;
                    cnt_nx   = CNT_W'(HOLD_CYCLES - 1);
                    last_nx  = sel_c;
                    b_nx     = onehot(sel_c);
                    gnt_nx   = sel_c;
                    busy_nx  = 1'b1;
                    if (HOLD_CYCLES == 1) begin
                        ack_nx = onehot(sel_c);
                    end
                end
            end
            GRANT: begin
                busy_nx = 1'b1;
                if (cnt == CNT_W'(0)) begin
                    state_nx = GAP;
                    cnt_nx   = CNT_W'(GAP_CYCLES - 1);
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                    b_nx   = b;
                    gnt_nx = gnt_id;
                    if (cnt == CNT_W'(1)) begin
                        ack_nx = b;
                    end
                end
            end
            GAP: begin
                if (cnt == CNT_W'(0)) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx  = cnt - CNT_W'(1);
                    busy_nx = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = CNT_W'(0);
            end
        endcase
    end

    // State, counter, round-robin pointer and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= CNT_W'(0);
            last_id <= 2'd3;
            b       <= 3'b000;
            gnt_id  <= 2'd0;
            ack     <= 3'b000;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            last_id <= last_nx;
            b       <= b_nx;
            gnt_id  <= gnt_nx;
            ack     <= ack_nx;
            busy    <= busy_nx;
        end
    end

endmodule
